life_grid_mem: RTL and testbench

LIFE_GRID_MEM -- requirements
Module: life_grid_mem

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_row_bank.sv | 48 ++++
 rtl/life_grid_mem.sv | 159 +++++++++++++++
 tb/tb_life_grid_mem.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types, preset pattern table and sizing helper for the life grid memory.
package life_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam int unsigned PRESET_W = 16;

    // Rows of the preset pattern, repeated every four grid rows.
    localparam logic [PRESET_W-1:0] PRESET [4] = '{
        16'h0600, 16'h3300, 16'h33CC, 16'h6186
    };

    // Address width for n entries, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/life_row_bank.sv
// One ROWS x COLS cell bank: a single write port and two registered read ports.
module life_row_bank #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned COLS   = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [COLS-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_a_row,
    output logic [COLS-1:0]   rd_a_data,
    input  logic [ADDR_W-1:0] rd_b_row,
    output logic [COLS-1:0]   rd_b_data
);

    localparam logic [ADDR_W:0] ROW_LIMIT = (ADDR_W+1)'(ROWS);

    logic [COLS-1:0] mem [ROWS];
    logic            wr_ok;
    logic            rd_a_ok;
    logic            rd_b_ok;

    // Rows beyond the grid are never written and always read as zero.
    assign wr_ok   = wr_en && ({1'b0, wr_row} < ROW_LIMIT);
    assign rd_a_ok = {1'b0, rd_a_row} < ROW_LIMIT;
    assign rd_b_ok = {1'b0, rd_b_row} < ROW_LIMIT;

    // Storage array; contents are defined by the clear sequence, not by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_row] <= wr_data;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_data <= '0;
            rd_b_data <= '0;
        end else begin
            rd_a_data <= rd_a_ok ? mem[rd_a_row] : '0;
            rd_b_data <= rd_b_ok ? mem[rd_b_row] : '0;
        end
    end

endmodule

// File: rtl/life_grid_mem.sv
// Double-buffered Game-of-Life grid: current bank is read, next bank is written, swap promotes.
module life_grid_mem
    import life_pkg::*;
#(
    parameter  int unsigned ROWS   = 16,
    parameter  int unsigned COLS   = 16,
    parameter  int unsigned GEN_W  = 16,
    localparam int unsigned ADDR_W = clog2_min1(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              clear_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] vga_row,
    output logic [COLS-1:0]   vga_data,
    input  logic [ADDR_W-1:0] sel_rd_row,
    output logic [COLS-1:0]   sel_rd_data,
    input  logic              sel_wr_en,
    input  logic [ADDR_W-1:0] sel_wr_row,
    input  logic [COLS-1:0]   sel_wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [GEN_W-1:0]  gen_count
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              bank_sel_q, bank_sel_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              swap_ack_q, swap_ack_d;
    logic              busy_q, busy_d;
    logic              rd_sel_q;

    logic              fill_en;
    logic [COLS-1:0]   fill_data;
    logic              idle_wr;

    logic              b0_wr_en, b1_wr_en;
    logic [ADDR_W-1:0] wr_row;
    logic [COLS-1:0]   wr_data;
    logic [COLS-1:0]   b0_vga, b0_sel, b1_vga, b1_sel;

    // Next-state, fill and swap decisions.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        bank_sel_d = bank_sel_q;
        gen_d      = gen_q;
        swap_ack_d = 1'b0;
        fill_en    = 1'b0;
        fill_data  = '0;
        idle_wr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_wr = sel_wr_en;
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                end else if (load_req) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                end else if (swap_req) begin
                    bank_sel_d = ~bank_sel_q;
                    gen_d      = gen_q + GEN_W'(1);
                    swap_ack_d = 1'b1;
                end
            end
            ST_CLEAR, ST_LOAD: begin
                fill_en = 1'b1;
                if (state_q == ST_LOAD) begin
                    fill_data = COLS'(PRESET[2'(row_q)]);
                end
                if (row_q == LAST_ROW) begin
                    state_d    = ST_IDLE;
                    bank_sel_d = 1'b0;
                    gen_d      = '0;
                end else begin
                    row_d = row_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control registers; reset lands in the clear sequence so both banks get zeroed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            row_q      <= '0;
            bank_sel_q <= 1'b0;
            gen_q      <= '0;
            swap_ack_q <= 1'b0;
            busy_q     <= 1'b1;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            bank_sel_q <= bank_sel_d;
            gen_q      <= gen_d;
            swap_ack_q <= swap_ack_d;
            busy_q     <= busy_d;
            rd_sel_q   <= bank_sel_q;
        end
    end

    // Fill sequences hit both banks; idle writes go to the bank that is next before any swap.
    assign b0_wr_en = fill_en | (idle_wr &  bank_sel_q);
    assign b1_wr_en = fill_en | (idle_wr & ~bank_sel_q);
    assign wr_row   = fill_en ? row_q     : sel_wr_row;
    assign wr_data  = fill_en ? fill_data : sel_wr_data;

    life_row_bank #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (b0_wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_a_row  (vga_row),
        .rd_a_data (b0_vga),
        .rd_b_row  (sel_rd_row),
        .rd_b_data (b0_sel)
    );

    life_row_bank #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (b1_wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_a_row  (vga_row),
        .rd_a_data (b1_vga),
        .rd_b_row  (sel_rd_row),
        .rd_b_data (b1_sel)
    );

    // Bank choice is captured with the read so a swap on the read edge still returns old data.
    assign vga_data    = rd_sel_q ? b1_vga : b0_vga;
    assign sel_rd_data = rd_sel_q ? b1_sel : b0_sel;
    assign busy        = busy_q;
    assign swap_ack    = swap_ack_q;
    assign gen_count   = gen_q;

endmodule

// File: tb/tb_life_grid_mem.sv
// Directed and random stimulus against a two-bank reference model of the life grid memory.
module tb_life_grid_mem;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int GEN_W = 16;
    localparam int AW    = 4;

    localparam logic [15:0] PAT [4] = '{16'h0600, 16'h3300, 16'h33CC, 16'h6186};

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req, clear_req, busy;
    logic [AW-1:0]     vga_row, sel_rd_row, sel_wr_row;
    logic [COLS-1:0]   vga_data, sel_rd_data, sel_wr_data;
    logic              sel_wr_en, swap_req, swap_ack;
    logic [GEN_W-1:0]  gen_count;

    always #5 clk = ~clk;

    life_grid_mem #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .clear_req   (clear_req),
        .busy        (busy),
        .vga_row     (vga_row),
        .vga_data    (vga_data),
        .sel_rd_row  (sel_rd_row),
        .sel_rd_data (sel_rd_data),
        .sel_wr_en   (sel_wr_en),
        .sel_wr_row  (sel_wr_row),
        .sel_wr_data (sel_wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .gen_count   (gen_count)
    );

    // Reference model: two plain arrays, index of the current one, cycles of fill left.
    logic [15:0] m_mem [2][ROWS];
    bit          m_val [2][ROWS];
    int          m_cur, m_gen, m_left;
    bit          m_load, m_ack;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_left = ROWS;
        m_load = 1'b0;
        m_cur  = 0;
        m_gen  = 0;
        m_ack  = 1'b0;
    endtask

    task automatic quiet();
        load_req = 0; clear_req = 0; sel_wr_en = 0; swap_req = 0;
    endtask

    // Advance one clock: update the model from the applied inputs, then compare outputs.
    task automatic tick();
        logic [15:0] ev, es;
        bit          vv, vs;
        int          r;
        ev = m_mem[m_cur][vga_row];    vv = m_val[m_cur][vga_row];
        es = m_mem[m_cur][sel_rd_row]; vs = m_val[m_cur][sel_rd_row];
        m_ack = 1'b0;
        if (m_left > 0) begin
            r = ROWS - m_left;
            for (int b = 0; b < 2; b++) begin
                m_mem[b][r] = m_load ? PAT[r % 4] : 16'h0000;
                m_val[b][r] = 1'b1;
            end
            m_left--;
            if (m_left == 0) begin
                m_cur = 0;
                m_gen = 0;
            end
        end else begin
            if (sel_wr_en) begin
                m_mem[1 - m_cur][sel_wr_row] = sel_wr_data;
                m_val[1 - m_cur][sel_wr_row] = 1'b1;
            end
            if (clear_req) begin
                m_left = ROWS; m_load = 1'b0;
            end else if (load_req) begin
                m_left = ROWS; m_load = 1'b1;
            end else if (swap_req) begin
                m_cur = 1 - m_cur;
                m_gen = (m_gen + 1) % (1 << GEN_W);
                m_ack = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("swap_ack", 32'(swap_ack), 32'(m_ack));
        chk("gen_count", 32'(gen_count), 32'(m_gen));
        if (vv) chk("vga_data", 32'(vga_data), 32'(ev));
        if (vs) chk("sel_rd_data", 32'(sel_rd_data), 32'(es));
    endtask

    // Tick until busy drops, bounded; returns the number of ticks taken.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_expect(input string tag, input int r, input logic [15:0] exp);
        vga_row    = AW'(r);
        sel_rd_row = AW'(ROWS - 1 - r);
        tick();
        chk(tag, 32'(vga_data), 32'(exp));
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        quiet();
        vga_row = '0; sel_rd_row = '0; sel_wr_row = '0; sel_wr_data = '0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) begin
                m_mem[b][r] = '0;
                m_val[b][r] = 1'b0;
            end
        model_reset();

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_gen", 32'(gen_count), 32'd0);
        chk("rst_ack", 32'(swap_ack), 32'd0);
        chk("rst_vga", 32'(vga_data), 32'd0);
        chk("rst_sel", 32'(sel_rd_data), 32'd0);
        rst = 1'b0;

        // Automatic clear after reset.
        wait_idle(cyc);
        chk("rst_clear_len", 32'(cyc), 32'(ROWS));
        for (int r = 0; r < ROWS; r++) read_expect("clr_row", r, 16'h0000);

        // Preset load.
        load_req = 1; tick(); quiet();
        wait_idle(cyc);
        chk("load_len", 32'(cyc), 32'(ROWS));
        for (int r = 0; r < 4; r++) read_expect("load_row", r, PAT[r]);
        read_expect("load_row5", 5, 16'h3300);
        chk("load_gen", 32'(gen_count), 32'd0);

        // Next-bank write is invisible until swapped in.
        sel_wr_en = 1; sel_wr_row = 4'd2; sel_wr_data = 16'hFFFF; tick(); quiet();
        read_expect("pre_swap_row2", 2, 16'h33CC);
        swap_req = 1; tick(); quiet();
        chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
        chk("swap_gen1", 32'(gen_count), 32'd1);
        read_expect("post_swap_row2", 2, 16'hFFFF);
        chk("swap_ack_clear", 32'(swap_ack), 32'd0);

        // Write in the swap cycle lands in the outgoing next bank; read in swap cycle sees old data.
        sel_wr_en = 1; sel_wr_row = 4'd7; sel_wr_data = 16'hA5A5;
        swap_req = 1; vga_row = 4'd2; tick(); quiet();
        chk("swap_cycle_read", 32'(vga_data), 32'h0000_FFFF);
        read_expect("wr_with_swap", 7, 16'hA5A5);

        // Simultaneous load and clear: clear wins.
        load_req = 1; clear_req = 1; tick(); quiet();
        wait_idle(cyc);
        chk("both_len", 32'(cyc), 32'(ROWS));
        for (int r = 0; r < ROWS; r++) read_expect("both_clr_row", r, 16'h0000);

        // Requests during busy are ignored.
        load_req = 1; tick(); quiet();
        tick();
        swap_req = 1; sel_wr_en = 1; sel_wr_row = 4'd1; sel_wr_data = 16'h1234; tick(); quiet();
        chk("busy_no_ack", 32'(swap_ack), 32'd0);
        chk("busy_gen", 32'(gen_count), 32'd0);
        wait_idle(cyc);
        swap_req = 1; tick(); quiet();
        read_expect("busy_no_write", 1, 16'h3300);

        // Reset in the middle of a load restarts a full clear.
        load_req = 1; tick(); quiet();
        repeat (3) tick();
        rst = 1'b1;
        model_reset();
        #2;
        chk("midload_rst_busy", 32'(busy), 32'd1);
        chk("midload_rst_gen", 32'(gen_count), 32'd0);
        chk("midload_rst_vga", 32'(vga_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle(cyc);
        chk("midload_clear_len", 32'(cyc), 32'(ROWS));
        for (int r = 0; r < ROWS; r++) read_expect("midload_clr_row", r, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            load_req    = ($urandom % 50) == 0;
            clear_req   = ($urandom % 60) == 0;
            swap_req    = ($urandom % 4) == 0;
            sel_wr_en   = ($urandom % 2) == 0;
            sel_wr_row  = AW'($urandom_range(ROWS - 1));
            sel_wr_data = 16'($urandom);
            vga_row     = AW'($urandom_range(ROWS - 1));
            sel_rd_row  = AW'($urandom_range(ROWS - 1));
            tick();
        end
        quiet();

        // Generation counter wrap.
        clear_req = 1; tick(); quiet();
        wait_idle(cyc);
        swap_req = 1;
        for (int i = 0; i < 65535; i++) tick();
        chk("gen_max", 32'(gen_count), 32'h0000_FFFF);
        tick();
        quiet();
        chk("gen_wrap", 32'(gen_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
